passcode_verifier: RTL

Parametrised keypad passcode engine. It enrolls a stored code of 1..MAX_LEN digits, collects user entries, and compares an entry against the stored code in a fixed-latency, constant-time serial scan. It reports match or mismatch, holds an unlocked status, and counts failed attempts. It sits between the keypad/switch front-end and the lock controller FSM.

---
 rtl/passcode_verifier.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/passcode_verifier.sv
// passcode_verifier
//   Keypad passcode engine. Enrolls a stored code of 1..MAX_LEN digits,
//   buffers user entries and checks an entry against the stored code with a
//   constant-time serial scan that always takes MAX_LEN cycles.
//
//   Optional feature macro: CODE_LOCKOUT_EN
//     defined   -> a mismatch that exhausts tries_left enters LOCKOUT for
//                  LOCKOUT_CYCLES cycles (locked=1, all inputs ignored).
//     undefined -> no LOCKOUT state, locked tied low; tries_left only counts.
//
//   Ports
//     clk, resetn       rising-edge clock, synchronous active-low reset
//     digit/digit_valid keypad digit and its 1-cycle strobe
//     mode_enroll       level: next commit enrolls (1) or verifies (0)
//     commit/clear      1-cycle strobes ending / discarding the entry
//     relock            1-cycle strobe clearing unlocked
//     busy              high in COMPARE and LOCKOUT
//     match/mismatch    1-cycle verify result pulses
//     enroll_ok/_err    1-cycle enroll result pulses
//     unlocked, code_set, locked   status levels
//     entry_count       digits currently buffered
//     tries_left        remaining attempts before lockout
//
//   Handshake: all input strobes are single-cycle pulses sampled on the
//   rising edge with no back-pressure. Strobes arriving while busy=1 are
//   dropped; the upstream front-end must watch busy and retry if needed.
//   The FSM state is held in the internal signal `state` (state_t) so
//   checkers can bind to it directly.
module passcode_verifier #(
  parameter int DIGIT_W        = 2,
  parameter int MAX_LEN        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             digit_valid,
  input  logic                             mode_enroll,
  input  logic                             commit,
  input  logic                             clear,
  input  logic                             relock,
  output logic                             busy,
  output logic                             match,
  output logic                             mismatch,
  output logic                             enroll_ok,
  output logic                             enroll_err,
  output logic                             unlocked,
  output logic                             code_set,
  output logic                             locked,
  output logic [$clog2(MAX_LEN+1)-1:0]     entry_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, LOCKOUT} state_t;

  state_t             state;
  logic [DIGIT_W-1:0] entry_buf  [MAX_LEN];
  logic [DIGIT_W-1:0] stored_buf [MAX_LEN];
  logic [CNT_W-1:0]   stored_len;
  logic [CNT_W-1:0]   idx;
  logic               overflow;
  logic               acc;

`ifdef CODE_LOCKOUT_EN
  localparam int LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  logic [LK_W-1:0] lock_cnt;
`endif

  logic             scan_ok;
  logic             final_ok;
  logic             last_idx;
  logic             enroll_accept;
  logic [TRY_W-1:0] tries_dec;

  // Positions past the stored length always pass, so stale stored digits
  // never influence the verdict; the length check catches short entries.
  assign scan_ok  = (idx >= stored_len) ||
                    (entry_buf[idx[IDX_W-1:0]] == stored_buf[idx[IDX_W-1:0]]);
  assign last_idx = (idx == CNT_W'(MAX_LEN - 1));
  assign final_ok = acc && scan_ok && (entry_count == stored_len) && !overflow;

  // A new code may replace an old one only while the user is unlocked.
  assign enroll_accept = (entry_count != '0) && !overflow && (!code_set || unlocked);
  assign tries_dec     = (tries_left == '0) ? '0 : tries_left - TRY_W'(1);

  assign busy = (state != IDLE);

`ifdef CODE_LOCKOUT_EN
  assign locked = (state == LOCKOUT);
`else
  // No lockout in this build; the duration parameter is still referenced so
  // both builds share one parameter list. The expression is constant 0.
  assign locked = (LOCKOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        entry_buf[i]  <= '0;
        stored_buf[i] <= '0;
      end
      stored_len  <= '0;
      idx         <= '0;
      acc         <= 1'b0;
      overflow    <= 1'b0;
      entry_count <= '0;
      match       <= 1'b0;
      mismatch    <= 1'b0;
      enroll_ok   <= 1'b0;
      enroll_err  <= 1'b0;
      unlocked    <= 1'b0;
      code_set    <= 1'b0;
      tries_left  <= TRY_W'(MAX_TRIES);
`ifdef CODE_LOCKOUT_EN
      lock_cnt    <= '0;
`endif
    end else begin
      match      <= 1'b0;
      mismatch   <= 1'b0;
      enroll_ok  <= 1'b0;
      enroll_err <= 1'b0;

      case (state)
        IDLE: begin
          if (relock) unlocked <= 1'b0;

          if (clear) begin
            entry_count <= '0;
            overflow    <= 1'b0;
          end else if (commit) begin
            if (mode_enroll) begin
              if (enroll_accept) begin
                for (int i = 0; i < MAX_LEN; i++) stored_buf[i] <= entry_buf[i];
                stored_len <= entry_count;
                code_set   <= 1'b1;
                enroll_ok  <= 1'b1;
              end else begin
                enroll_err <= 1'b1;
              end
              entry_count <= '0;
              overflow    <= 1'b0;
            end else if (!code_set) begin
              mismatch    <= 1'b1;
              entry_count <= '0;
              overflow    <= 1'b0;
            end else begin
              state <= COMPARE;
              idx   <= '0;
              acc   <= 1'b1;
            end
          end else if (digit_valid) begin
            if (entry_count == CNT_W'(MAX_LEN)) begin
              overflow <= 1'b1;
            end else begin
              entry_buf[entry_count[IDX_W-1:0]] <= digit;
              entry_count <= entry_count + CNT_W'(1);
            end
          end
        end

        COMPARE: begin
          // Scan length is fixed at MAX_LEN so timing reveals nothing.
          acc <= acc && scan_ok;
          idx <= idx + CNT_W'(1);
          if (last_idx) begin
            state       <= IDLE;
            entry_count <= '0;
            overflow    <= 1'b0;
            if (final_ok) begin
              match      <= 1'b1;
              unlocked   <= 1'b1;
              tries_left <= TRY_W'(MAX_TRIES);
            end else begin
              mismatch   <= 1'b1;
              tries_left <= tries_dec;
`ifdef CODE_LOCKOUT_EN
              if (tries_left == TRY_W'(1)) begin
                state    <= LOCKOUT;
                lock_cnt <= LK_W'(LOCKOUT_CYCLES - 1);
              end
`endif
            end
          end
        end

`ifdef CODE_LOCKOUT_EN
        LOCKOUT: begin
          if (lock_cnt == '0) begin
            state      <= IDLE;
            tries_left <= TRY_W'(MAX_TRIES);
          end else begin
            lock_cnt <= lock_cnt - LK_W'(1);
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
